// File: rtl/snd_mbox_pkg.sv
// snd_mbox_pkg
//   Shared definitions for the sound-command mailbox:
//   - clog2_min1(): width helper, never returns less than 1
//   - cmd_word_t:   command word type for the default DW=8 build
//   - LEGACY_*:     parameter set reproducing the old single SNDRQ/SNDNO latch
package snd_mbox_pkg;

  // Bits needed to index 'value' items, with a floor of 1 so that
  // single-entry / single-channel builds still get a legal vector.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  typedef logic [7:0] cmd_word_t;

  // DEPTH=1 with overwrite behaves exactly like the legacy latch pair.
  localparam int LEGACY_DEPTH     = 1;
  localparam bit LEGACY_OVERWRITE = 1'b1;

endpackage

// File: rtl/snd_mbox_fifo.sv
// snd_mbox_fifo
//   One command channel: DEPTH-entry FIFO with occupancy count, full/irq
//   flags, optional overwrite-on-full and a sticky overflow flag.
//   Optional macro SND_CMD_MAILBOX_LEVEL_EN adds level/hwm outputs.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   wr_en/wr_data write strobe and word (already channel-decoded)
//   rd_en         pop request (already channel-decoded)
//   ovf_clr       clears the sticky overflow (and high-water mark)
//   rd_data       entry at the read pointer (valid when pop=1)
//   pop           the pop request is being honoured this cycle
//   full, irq     count==DEPTH, count!=0
//   ovf           sticky overflow
//   level, hwm    current count / high-water mark (LEVEL_EN only)
module snd_mbox_fifo
  import snd_mbox_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int DW        = 8,
  parameter bit OVERWRITE = 1'b0,
  localparam int AW       = clog2_min1(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic          ovf_clr,
  output logic [DW-1:0] rd_data,
  output logic          pop,
  output logic          full,
  output logic          irq,
  output logic          ovf
`ifdef SND_CMD_MAILBOX_LEVEL_EN
  ,
  output logic [AW:0]   level,
  output logic [AW:0]   hwm
`endif
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  // Storage is sized to the full pointer range so a DEPTH=1 build (1-bit
  // pointer pinned at 0) never indexes past the array.
  logic [DW-1:0] mem_q [2**AW];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          ovf_set;
  logic          wr_acc;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (DEPTH == 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
    return (DEPTH == 1) ? '0 : p - 1'b1;
  endfunction

  assign full    = (count_q == DEPTH_CNT);
  assign irq     = (count_q != '0);
  assign pop     = rd_en && irq;
  assign rd_data = mem_q[rptr_q];
  assign ovf     = ovf_q;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    ovf_set   = 1'b0;
    wr_acc    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wptr_q;

    if (pop) rptr_d = ptr_inc(rptr_q);

    if (wr_en) begin
      // A pop in the same cycle frees a slot first, so a full channel
      // still accepts the write without flagging overflow.
      if (!full || pop) begin
        wr_acc = 1'b1;
        mem_we = 1'b1;
        wptr_d = ptr_inc(wptr_q);
      end else begin
        ovf_set = 1'b1;
        if (OVERWRITE) begin
          mem_we    = 1'b1;
          mem_waddr = ptr_dec(wptr_q);
        end
      end
    end

    if (wr_acc && !pop)      count_d = count_q + 1'b1;
    else if (!wr_acc && pop) count_d = count_q - 1'b1;

    // Set beats clear when both land on the same cycle.
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Contents need no reset: zeroed pointers/count make every entry stale.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= wr_data;
  end

`ifdef SND_CMD_MAILBOX_LEVEL_EN
  logic [AW:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = ovf_clr ? '0 : hwm_q;
    if (count_d > hwm_d) hwm_d = count_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hwm_q <= '0;
    else     hwm_q <= hwm_d;
  end

  assign level = count_q;
  assign hwm   = hwm_q;
`endif

endmodule

// File: rtl/snd_cmd_mailbox.sv
// snd_cmd_mailbox
//   Main-CPU -> sound-CPU command path: CHANNELS independent FIFOs with
//   per-channel IRQ/FULL/OVF and a shared registered read port.
//   Optional macro SND_CMD_MAILBOX_LEVEL_EN adds LEVEL and HWM outputs.
// Ports:
//   MCLK, RESET       clock, asynchronous active-high reset
//   WR_EN/WR_CH/WR_DT write strobe, channel, word
//   RD_EN/RD_CH       pop strobe and channel
//   RD_DT/RD_VLD      registered popped word and one-cycle valid
//   IRQ/FULL/OVF      per-channel not-empty, full, sticky overflow
//   OVF_CLR           per-channel overflow clear
//   LEVEL/HWM         packed per-channel count / high-water (LEVEL_EN only)
// Channel indices >= CHANNELS match no generate slice and are ignored.
module snd_cmd_mailbox
  import snd_mbox_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int DEPTH     = 4,
  parameter int DW        = 8,
  parameter bit OVERWRITE = 1'b0,
  localparam int CW       = clog2_min1(CHANNELS),
  localparam int AW       = clog2_min1(DEPTH)
) (
  input  logic                MCLK,
  input  logic                RESET,
  input  logic                WR_EN,
  input  logic [CW-1:0]       WR_CH,
  input  logic [DW-1:0]       WR_DT,
  input  logic                RD_EN,
  input  logic [CW-1:0]       RD_CH,
  output logic [DW-1:0]       RD_DT,
  output logic                RD_VLD,
  output logic [CHANNELS-1:0] IRQ,
  output logic [CHANNELS-1:0] FULL,
  output logic [CHANNELS-1:0] OVF,
  input  logic [CHANNELS-1:0] OVF_CLR
`ifdef SND_CMD_MAILBOX_LEVEL_EN
  ,
  output logic [CHANNELS*(AW+1)-1:0] LEVEL,
  output logic [CHANNELS*(AW+1)-1:0] HWM
`endif
);

  logic [DW-1:0]       ch_rd_data [CHANNELS];
  logic [CHANNELS-1:0] ch_pop;

  logic [DW-1:0] rd_dt_q, rd_dt_d;
  logic          rd_vld_q, rd_vld_d;
  logic [DW-1:0] rd_mux;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic wr_sel;
    logic rd_sel;

    assign wr_sel = WR_EN && (WR_CH == CW'(gi));
    assign rd_sel = RD_EN && (RD_CH == CW'(gi));

    snd_mbox_fifo #(
      .DEPTH     (DEPTH),
      .DW        (DW),
      .OVERWRITE (OVERWRITE)
    ) u_fifo (
      .clk     (MCLK),
      .rst     (RESET),
      .wr_en   (wr_sel),
      .wr_data (WR_DT),
      .rd_en   (rd_sel),
      .ovf_clr (OVF_CLR[gi]),
      .rd_data (ch_rd_data[gi]),
      .pop     (ch_pop[gi]),
      .full    (FULL[gi]),
      .irq     (IRQ[gi]),
      .ovf     (OVF[gi])
`ifdef SND_CMD_MAILBOX_LEVEL_EN
      ,
      .level   (LEVEL[gi*(AW+1) +: AW+1]),
      .hwm     (HWM[gi*(AW+1) +: AW+1])
`endif
    );
  end

  // At most one channel pops per cycle, so a priority mux is sufficient.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_pop[i]) rd_mux = ch_rd_data[i];
    end
    rd_vld_d = |ch_pop;
    rd_dt_d  = rd_vld_d ? rd_mux : rd_dt_q;
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      rd_dt_q  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_dt_q  <= rd_dt_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  assign RD_DT  = rd_dt_q;
  assign RD_VLD = rd_vld_q;

endmodule

// File: tb/tb_snd_cmd_mailbox.sv
module tb_snd_cmd_mailbox;
  import snd_mbox_pkg::*;

  localparam int CH  = 2;
  localparam int DEP = 4;

  logic        MCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        WR_EN = 1'b0;
  logic [0:0]  WR_CH = '0;
  cmd_word_t   WR_DT = '0;
  logic        RD_EN = 1'b0;
  logic [0:0]  RD_CH = '0;
  logic [1:0]  OVF_CLR = '0;

  cmd_word_t   RD_DT;
  logic        RD_VLD;
  logic [1:0]  IRQ, FULL, OVF;

  cmd_word_t   l_rd_dt;
  logic        l_rd_vld;
  logic [0:0]  l_irq, l_full, l_ovf;

`ifdef SND_CMD_MAILBOX_LEVEL_EN
  logic [5:0] LEVEL, HWM;
  logic [1:0] l_level, l_hwm;
`endif

  always #5 MCLK = ~MCLK;

  snd_cmd_mailbox #(.CHANNELS(CH), .DEPTH(DEP), .DW(8), .OVERWRITE(1'b0)) dut (
    .MCLK(MCLK), .RESET(RESET), .WR_EN(WR_EN), .WR_CH(WR_CH), .WR_DT(WR_DT),
    .RD_EN(RD_EN), .RD_CH(RD_CH), .RD_DT(RD_DT), .RD_VLD(RD_VLD),
    .IRQ(IRQ), .FULL(FULL), .OVF(OVF), .OVF_CLR(OVF_CLR)
`ifdef SND_CMD_MAILBOX_LEVEL_EN
    , .LEVEL(LEVEL), .HWM(HWM)
`endif
  );

  // Legacy single-latch configuration; channel 1 is out of range here.
  snd_cmd_mailbox #(.CHANNELS(1), .DEPTH(LEGACY_DEPTH), .DW(8), .OVERWRITE(LEGACY_OVERWRITE)) dut_legacy (
    .MCLK(MCLK), .RESET(RESET), .WR_EN(WR_EN), .WR_CH(WR_CH), .WR_DT(WR_DT),
    .RD_EN(RD_EN), .RD_CH(RD_CH), .RD_DT(l_rd_dt), .RD_VLD(l_rd_vld),
    .IRQ(l_irq), .FULL(l_full), .OVF(l_ovf), .OVF_CLR(OVF_CLR[0:0])
`ifdef SND_CMD_MAILBOX_LEVEL_EN
    , .LEVEL(l_level), .HWM(l_hwm)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the main instance: one queue per channel.
  logic [7:0] mq [CH][$];
  logic [1:0] m_ovf = '0;
  logic [7:0] m_rd_dt = '0;
  logic       m_rd_vld = 1'b0;
  int         m_hwm [CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      mq[i].delete();
      m_hwm[i] = 0;
    end
    m_ovf = '0;
    m_rd_dt = '0;
    m_rd_vld = 1'b0;
  endtask

  task automatic model_step(input logic we, input int wch, input logic [7:0] wd,
                            input logic re, input int rch, input logic [1:0] clr);
    logic [1:0] set;
    set = '0;
    m_rd_vld = 1'b0;
    // Pop first: a full channel that is also read makes room for the write.
    if (re && rch < CH && mq[rch].size() > 0) begin
      m_rd_dt = mq[rch].pop_front();
      m_rd_vld = 1'b1;
    end
    if (we && wch < CH) begin
      if (mq[wch].size() < DEP) mq[wch].push_back(wd);
      else set[wch] = 1'b1;
    end
    m_ovf = (m_ovf & ~clr) | set;
    for (int i = 0; i < CH; i++) begin
      if (clr[i]) m_hwm[i] = 0;
      if (mq[i].size() > m_hwm[i]) m_hwm[i] = mq[i].size();
    end
  endtask

  task automatic compare_model();
    logic [1:0] irq_e, full_e;
`ifdef SND_CMD_MAILBOX_LEVEL_EN
    logic [5:0] lvl_e, hwm_e;
    lvl_e = '0;
    hwm_e = '0;
`endif
    for (int i = 0; i < CH; i++) begin
      irq_e[i]  = (mq[i].size() != 0);
      full_e[i] = (mq[i].size() == DEP);
`ifdef SND_CMD_MAILBOX_LEVEL_EN
      lvl_e[i*3 +: 3] = 3'(mq[i].size());
      hwm_e[i*3 +: 3] = 3'(m_hwm[i]);
`endif
    end
    check("irq", 32'(IRQ), 32'(irq_e));
    check("full", 32'(FULL), 32'(full_e));
    check("ovf", 32'(OVF), 32'(m_ovf));
    check("rd_vld", 32'(RD_VLD), 32'(m_rd_vld));
    check("rd_dt", 32'(RD_DT), 32'(m_rd_dt));
`ifdef SND_CMD_MAILBOX_LEVEL_EN
    check("level", 32'(LEVEL), 32'(lvl_e));
    check("hwm", 32'(HWM), 32'(hwm_e));
`endif
  endtask

  // One clock: drive after a falling edge, model at the rising edge,
  // compare at the next falling edge.
  task automatic cyc(input logic we, input int wch, input logic [7:0] wd,
                     input logic re, input int rch, input logic [1:0] clr);
    WR_EN = we; WR_CH = 1'(wch); WR_DT = wd;
    RD_EN = re; RD_CH = 1'(rch); OVF_CLR = clr;
    @(posedge MCLK);
    model_step(we, wch, wd, re, rch, clr);
    @(negedge MCLK);
    compare_model();
    WR_EN = 1'b0; RD_EN = 1'b0; OVF_CLR = '0;
  endtask

  task automatic wr(input int ch, input logic [7:0] d);
    cyc(1'b1, ch, d, 1'b0, 0, 2'b00);
  endtask

  task automatic rd(input int ch);
    cyc(1'b0, 0, 8'h00, 1'b1, ch, 2'b00);
  endtask

  initial begin
    logic [7:0] exp_seq [4];
    model_reset();

    // Reset state
    repeat (2) @(negedge MCLK);
    check("rst_irq", 32'(IRQ), 0);
    check("rst_full", 32'(FULL), 0);
    check("rst_ovf", 32'(OVF), 0);
    check("rst_rd_dt", 32'(RD_DT), 0);
    check("rst_rd_vld", 32'(RD_VLD), 0);
    check("rst_l_irq", 32'(l_irq), 0);
    RESET = 1'b0;
    cyc(1'b0, 0, 8'h00, 1'b0, 0, 2'b00);

    // 1: basic FIFO order on ch0
    wr(0, 8'h11);
    check("t1_irq_after_first_wr", 32'(IRQ[0]), 1);
    wr(0, 8'h22);
    wr(0, 8'h33);
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      rd(0);
      check("t1_rd_dt", 32'(RD_DT), 32'(exp_seq[i]));
      check("t1_rd_vld", 32'(RD_VLD), 1);
    end
    check("t1_irq_empty", 32'(IRQ[0]), 0);
    cyc(1'b0, 0, 8'h00, 1'b0, 0, 2'b01);
    check("t1_l_ovf_cleared", 32'(l_ovf), 0);

    // 2: overflow without overwrite on ch1
    for (int i = 1; i <= 5; i++) begin
      wr(1, 8'(i));
      if (i == 4) check("t2_full_after_4", 32'(FULL[1]), 1);
      if (i == 4) check("t2_ovf_before_5", 32'(OVF[1]), 0);
      if (i == 5) check("t2_ovf_after_5", 32'(OVF[1]), 1);
    end
    check("t2_l_irq_out_of_range", 32'(l_irq), 0);
    check("t2_l_ovf_out_of_range", 32'(l_ovf), 0);
    for (int i = 1; i <= 4; i++) begin
      rd(1);
      check("t2_rd_dt", 32'(RD_DT), 32'(i));
    end
    check("t2_l_rd_vld_out_of_range", 32'(l_rd_vld), 0);
    check("t2_l_rd_dt_hold", 32'(l_rd_dt), 32'h33);
    check("t2_ovf_sticky", 32'(OVF[1]), 1);
    cyc(1'b0, 0, 8'h00, 1'b0, 0, 2'b10);
    check("t2_ovf_clr", 32'(OVF[1]), 0);

    // 3: legacy DEPTH=1 overwrite
    wr(0, 8'hA0);
    check("t3_l_irq", 32'(l_irq), 1);
    wr(0, 8'hA5);
    check("t3_l_ovf", 32'(l_ovf), 1);
    check("t3_l_full", 32'(l_full), 1);
    rd(0);
    check("t3_l_rd_dt", 32'(l_rd_dt), 32'hA5);
    check("t3_l_rd_vld", 32'(l_rd_vld), 1);
    check("t3_l_irq_empty", 32'(l_irq), 0);
    rd(0);

    // 4: full ch0 with simultaneous write and read
    for (int i = 0; i < 4; i++) wr(0, 8'hC1 + 8'(i));
    check("t4_full", 32'(FULL[0]), 1);
    cyc(1'b1, 0, 8'h77, 1'b1, 0, 2'b00);
    check("t4_rd_oldest", 32'(RD_DT), 32'hC1);
    check("t4_full_stays", 32'(FULL[0]), 1);
    check("t4_no_ovf", 32'(OVF[0]), 0);
    for (int i = 0; i < 4; i++) rd(0);
    check("t4_last_rd", 32'(RD_DT), 32'h77);
    check("t4_empty", 32'(IRQ[0]), 0);

    // 5: read of empty ch1 with a write to ch0 in the same cycle
    wr(0, 8'h33);
    rd(0);
    check("t5_setup", 32'(RD_DT), 32'h33);
    cyc(1'b1, 0, 8'h44, 1'b1, 1, 2'b00);
    check("t5_rd_dt_hold", 32'(RD_DT), 32'h33);
    check("t5_rd_vld", 32'(RD_VLD), 0);
    check("t5_wr_accepted", 32'(IRQ[0]), 1);

    // Randomized traffic: write-heavy then read-heavy phases
    for (int n = 0; n < 400; n++) begin
      logic we, re;
      logic [1:0] clr;
      if (n < 200) begin
        we = ($urandom_range(0, 3) != 0);
        re = ($urandom_range(0, 3) == 0);
      end else begin
        we = ($urandom_range(0, 3) == 0);
        re = ($urandom_range(0, 3) != 0);
      end
      clr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      cyc(we, $urandom_range(0, 1), 8'($urandom), re, $urandom_range(0, 1), clr);
    end

    // Drain and clear before the reset test
    for (int i = 0; i < 4; i++) rd(0);
    for (int i = 0; i < 4; i++) rd(1);
    cyc(1'b0, 0, 8'h00, 1'b0, 0, 2'b11);
    check("drain_irq", 32'(IRQ), 0);

    // 6: asynchronous reset with entries queued
    wr(0, 8'h55);
    wr(0, 8'h66);
    for (int i = 0; i < 5; i++) wr(1, 8'hE0 + 8'(i));
`ifdef SND_CMD_MAILBOX_LEVEL_EN
    check("t6_hwm0_before", 32'(HWM[2:0]), 2);
`endif
    rd(1);
    check("t6_pre_vld", 32'(RD_VLD), 1);
    check("t6_pre_ovf", 32'(OVF[1]), 1);
    #2 RESET = 1'b1;
    #1;
    check("t6_irq", 32'(IRQ), 0);
    check("t6_full", 32'(FULL), 0);
    check("t6_ovf", 32'(OVF), 0);
    check("t6_rd_dt", 32'(RD_DT), 0);
    check("t6_rd_vld", 32'(RD_VLD), 0);
`ifdef SND_CMD_MAILBOX_LEVEL_EN
    check("t6_level", 32'(LEVEL), 0);
    check("t6_hwm", 32'(HWM), 0);
`endif
    model_reset();
    @(negedge MCLK);
    RESET = 1'b0;
    cyc(1'b0, 0, 8'h00, 1'b0, 0, 2'b00);
    rd(0);
    check("t6_discarded", 32'(RD_VLD), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snd_cmd_mailbox.md
Name: snd_cmd_mailbox

Overview:
- Parametrised main-CPU to sound-CPU command path; successor to the single SNDRQ/SNDNO latch pair.
- Provides CHANNELS independent command FIFOs, each DEPTH entries of DW bits, with per-channel IRQ and status.
- Sits between the main CPU write decode and one or more sound CPUs, all on MCLK.
- DEPTH=1 with OVERWRITE=1 reproduces the legacy single-latch behaviour.

Parameters:
- CHANNELS, 2, number of independent command channels (1..8).
- DEPTH, 4, entries per channel FIFO; power of two, 1..16.
- DW, 8, command word width.
- OVERWRITE, 0, 1 = a write to a full channel replaces the newest entry; 0 = the write is dropped and flagged.
- CW (localparam) = max(1, clog2(CHANNELS)).
- AW (localparam) = max(1, clog2(DEPTH)).

Ports:
- MCLK  in  1  system clock.
- RESET  in  1  asynchronous reset, active-high.
- WR_EN  in  1  single-cycle write strobe from the main CPU.
- WR_CH  in  CW  target channel of the write.
- WR_DT  in  DW  command word.
- RD_EN  in  1  single-cycle read/pop strobe from the sound CPU.
- RD_CH  in  CW  channel to pop.
- RD_DT  out  DW  popped word, registered.
- RD_VLD  out  1  one-cycle pulse: RD_DT updated by a successful pop.
- IRQ  out  CHANNELS  per channel, high while that channel is not empty.
- FULL  out  CHANNELS  per channel full flag.
- OVF  out  CHANNELS  sticky overflow flag.
- OVF_CLR  in  CHANNELS  per-bit clear of OVF.

Behaviour:
- Reset (asynchronous, immediate):
  - all pointers and counts = 0.
  - RD_DT = 0, RD_VLD = 0, IRQ = 0, FULL = 0, OVF = 0.
  - A reset in the middle of any access discards all queued entries.
- Channel index out of range (>= CHANNELS): the access is ignored and no flag changes.
- Write, channel not full: store the word at wptr; wptr += 1 modulo DEPTH; count += 1. IRQ/FULL reflect the new count on the next cycle (1-cycle latency).
- Write, channel full:
  - OVERWRITE=0: word dropped, OVF[ch] set.
  - OVERWRITE=1: the newest entry at wptr-1 is replaced, count is unchanged, OVF[ch] set.
- Read, channel not empty: RD_DT <= entry at rptr; RD_VLD = 1 for the next cycle; rptr += 1 modulo DEPTH; count -= 1.
- Read, channel empty: RD_DT holds its value, RD_VLD = 0, no state change.
- Simultaneous write and read on the same channel:
  - Full: the pop happens first, so the write is accepted and OVF is not set.
  - Empty: the write is accepted; the read returns nothing and RD_VLD = 0. No fall-through.
  - Otherwise: count is unchanged and both pointers advance.
- Simultaneous write and read on different channels: handled independently in the same cycle.
- OVF_CLR and an overflow event on the same bit in the same cycle: set wins.
- Pointer and count arithmetic:
  - count is AW+1 bits; FULL = (count == DEPTH); IRQ = (count != 0).
  - Pointers wrap naturally at AW bits.
  - DEPTH=1: AW=1; the pointer is forced to 0.

Optional Feature:
- Macro: SND_CMD_MAILBOX_LEVEL_EN.
- Defined:
  - Adds output LEVEL, width CHANNELS*(AW+1): the per-channel count, channel 0 in the LSBs, registered, same timing as FULL.
  - Adds a high-water sticky register per channel, reset 0, cleared by OVF_CLR; exposed on output HWM with the same packing as LEVEL.
- Undefined: neither port nor the associated logic exists; all other behaviour is identical.

Decomposition:
- Shared package snd_mbox_pkg:
  - clog2-based width helper functions.
  - Command-word typedef for DW=8.
  - Legacy-mode constants (DEPTH=1, OVERWRITE=1).
- One sub-module, snd_mbox_fifo: a single-channel FIFO with count, full/empty, overwrite and overflow logic, instantiated CHANNELS times by a generate loop.
- The top level holds channel decode, the read mux, and RD_DT/RD_VLD.

Test Plan:
1. Reset, then write 0x11, 0x22, 0x33 to ch0 -> IRQ[0]=1 one cycle after the first write; three reads give RD_DT 0x11, 0x22, 0x33, each with RD_VLD; IRQ[0]=0 after the third.
2. DEPTH=4, OVERWRITE=0: five writes 0x01..0x05 to ch1 -> FULL[1]=1 after the fourth, OVF[1]=1 after the fifth; reads give 0x01..0x04; OVF_CLR[1] clears OVF.
3. OVERWRITE=1, DEPTH=1: writes 0xA0 then 0xA5 -> a single read returns 0xA5, OVF[0]=1.
4. Full ch0 with simultaneous WR 0x77 and RD -> RD_DT = oldest entry, FULL stays 1, OVF[0]=0; the last read returns 0x77.
5. Read of empty ch1 while RD_DT=0x33 -> RD_DT stays 0x33, RD_VLD=0; write to ch0 in the same cycle is accepted.
6. Assert RESET asynchronously with two entries queued -> all outputs 0 immediately. With SND_CMD_MAILBOX_LEVEL_EN defined, LEVEL=0; HWM=2 before the reset and 0 after it.
